pipe_vect_elastic: RTL
======================

# pipe_vect_elastic

Parametrised elastic pipeline stage for the vector ASIP datapath. It carries one scalar control word plus NUM_VECT vector operands between pipeline stages using a valid/ready handshake. A two-entry buffer (main + skid) sustains one transfer per cycle while keeping in_ready free of any combinational path from out_ready. It also supports a synchronous flush for branch/hazard squashing, and full reset of every output.

## Interface
- WIDTH, 8: scalar control/instruction word width.
- REG_SIZE, 16: bits per vector element.
- VECT_SIZE, 4: elements per vector.
- NUM_VECT, 3: number of vector operands carried.
- CNT_WIDTH, 16: stall counter width (used only with PIPE_VECT_ELASTIC_STATS_EN).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; registered.
- in_ctrl  in  WIDTH  scalar word.
- in_vect  in  [NUM_VECT][VECT_SIZE][REG_SIZE]  vector operands.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  WIDTH  scalar word of head entry.
- out_vect  out  [NUM_VECT][VECT_SIZE][REG_SIZE]  vectors of head entry.
- stall_cnt  out  CNT_WIDTH  back-pressure cycle count; present only with the macro.

## Operation
- Accept = in_valid && in_ready. Emit = out_valid && out_ready.
- Storage: MAIN entry drives out_*; SKID entry holds overflow.
- States:
  - EMPTY: no entries.
  - ONE: MAIN valid.
  - FULL: MAIN and SKID valid.
- Outputs: out_valid = (state != EMPTY). in_ready = (state != FULL), decoded from state flops.
- Transitions:
  - EMPTY + accept -> ONE; MAIN <= in.
  - ONE + accept + emit -> ONE; MAIN <= in.
  - ONE + accept, no emit -> FULL; SKID <= in.
  - ONE + emit, no accept -> EMPTY.
  - FULL + emit -> ONE; MAIN <= SKID. No accept is possible in FULL.
  - Otherwise hold all state.
- Flush has the highest priority. On the next edge the state goes to EMPTY and any concurrent accept is discarded. Data registers hold their contents; they are don't-care while out_valid=0.
- Order is strictly FIFO. No entry is dropped or duplicated except by flush.
- out_ctrl and out_vect change only on an edge, never combinationally from the inputs.

## Timing
- Reset (reset_n=0, asynchronous):
  - state=EMPTY, so out_valid=0 and in_ready=1.
  - out_ctrl=0, out_vect=0 (all lanes), SKID=0.
  - stall_cnt=0.
- Deassertion of reset takes effect at the next rising edge; the first accept is possible at that edge.
- Latency: an entry accepted at edge N is visible on out_* with out_valid=1 after edge N, when it enters an empty stage.
- Throughput: one entry per cycle when out_ready is held at 1.
- Back-pressure: with out_ready=0, a second accept moves the stage to FULL. in_ready drops after that edge. At most 2 entries are ever held.
- out_valid=1 with out_ready=0: out_* stays stable until emit.
- Reset asserted mid-transfer: all entries are lost immediately, and the outputs take their reset values asynchronously.

## Configuration
- PIPE_VECT_ELASTIC_STATS_EN defined:
  - Adds the stall_cnt port and counter.
  - The counter increments on each edge where out_valid=1 and out_ready=0, and saturates at all-ones.
  - It is cleared only by reset_n, not by flush.
- Macro undefined: no stall_cnt port and no counter logic. All other behaviour is identical.

## Test plan
- Reset/default check:
  - Stimulus: assert reset_n=0 mid-stream with both entries full.
  - Required: out_valid=0, in_ready=1, out_ctrl=0 and out_vect=0 immediately, without waiting for clk.
- Streaming:
  - Stimulus: out_ready=1; send ctrl 0x01..0x10 with distinct vector patterns on consecutive cycles.
  - Required: each appears one cycle after acceptance, in order, with zero bubbles.
- Back-pressure:
  - Stimulus: out_ready=0; send 0xA1, 0xA2, 0xA3.
  - Required: 0xA1 and 0xA2 are accepted, and in_ready=0 after the second accept.
  - Stimulus: release out_ready.
  - Required: output order 0xA1, 0xA2, 0xA3; out_* stable while stalled.
- Flush:
  - Stimulus: in FULL, assert flush together with in_valid=1 (ctrl 0x55).
  - Required: next cycle out_valid=0 and in_ready=1, and 0x55 never appears at the output.
- Random handshake:
  - Stimulus: 1000 entries with random in_valid/out_ready.
  - Required: scoreboard matches with no loss or duplication; in_ready never depends combinationally on out_ready.
- Stats (macro defined):
  - Stimulus: hold out_ready=0 for 5 cycles with out_valid=1.
  - Required: stall_cnt=5; flush leaves it at 5; with CNT_WIDTH=2 the counter saturates at 3.

Source files
------------

// File: rtl/pipe_vect_elastic.sv
// -----------------------------------------------------------------------------
// pipe_vect_elastic
//   Elastic pipeline stage for the vector ASIP datapath. Carries one scalar
//   control word plus NUM_VECT vector operands between stages under a
//   valid/ready handshake. A two-entry buffer (MAIN + SKID) sustains one
//   transfer per cycle. in_ready and out_valid are decoded only from the
//   state flops, so neither has a combinational path from out_ready or
//   in_valid.
//
//   Optional feature macro: PIPE_VECT_ELASTIC_STATS_EN
//     When defined, adds the stall_cnt output: a saturating count of edges
//     where out_valid=1 and out_ready=0. Only reset_n clears it; flush
//     does not.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   flush      in   synchronous squash of all buffered entries (top priority)
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can accept (decoded from state flops)
//   in_ctrl    in   scalar control word [WIDTH]
//   in_vect    in   vector operands [NUM_VECT][VECT_SIZE][REG_SIZE]
//   out_valid  out  head entry valid
//   out_ready  in   downstream accepts
//   out_ctrl   out  scalar word of the head entry (registered)
//   out_vect   out  vectors of the head entry (registered)
//   stall_cnt  out  back-pressure cycle count [CNT_WIDTH] (macro only)
// -----------------------------------------------------------------------------
module pipe_vect_elastic #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned REG_SIZE  = 16,
  parameter int unsigned VECT_SIZE = 4,
  parameter int unsigned NUM_VECT  = 3,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          flush,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [WIDTH-1:0]                              in_ctrl,
  input  logic [NUM_VECT-1:0][VECT_SIZE-1:0][REG_SIZE-1:0] in_vect,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [WIDTH-1:0]                              out_ctrl,
  output logic [NUM_VECT-1:0][VECT_SIZE-1:0][REG_SIZE-1:0] out_vect
`ifdef PIPE_VECT_ELASTIC_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]                          stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;

  // MAIN entry drives the outputs directly; SKID holds the overflow entry.
  logic [WIDTH-1:0]                                 main_ctrl;
  logic [NUM_VECT-1:0][VECT_SIZE-1:0][REG_SIZE-1:0] main_vect;
  logic [WIDTH-1:0]                                 skid_ctrl;
  logic [NUM_VECT-1:0][VECT_SIZE-1:0][REG_SIZE-1:0] skid_vect;

  logic accept;
  logic emit;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  assign out_ctrl  = main_ctrl;
  assign out_vect  = main_vect;

  // Data registers are written only on the transitions that need them; on
  // flush they keep their contents since out_valid=0 makes them don't-care.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_vect <= '0;
      skid_ctrl <= '0;
      skid_vect <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            main_ctrl <= in_ctrl;
            main_vect <= in_vect;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_ctrl <= in_ctrl;
            main_vect <= in_vect;
          end else if (accept) begin
            state     <= FULL;
            skid_ctrl <= in_ctrl;
            skid_vect <= in_vect;
          end else if (emit) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // in_ready=0 here, so only the head can move.
          if (emit) begin
            state     <= ONE;
            main_ctrl <= skid_ctrl;
            main_vect <= skid_vect;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_VECT_ELASTIC_STATS_EN
  // Saturating stall counter; flush intentionally leaves it untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
